// File: rtl/axi4_pkg.sv
// AXI4 field widths shared by the DMA blocks.
// Only the widths the write scheduler needs live here.
package axi4_pkg;
  localparam int BURST_BITS = 2;
  localparam int SIZE_BITS  = 3;
endpackage

// File: rtl/dmac_pkg.sv
// DMA controller shared types: channel/scheduler states and
// the outstanding-burst FIFO entry.
package dmac_pkg;
  localparam int BURST_BITS = axi4_pkg::BURST_BITS;
  localparam int SIZE_BITS  = axi4_pkg::SIZE_BITS;
  localparam int CH_IDX_W   = 8;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ACTIVE,
    CH_DRAIN
  } ch_state_e;

  typedef enum logic {
    S_ARB,
    S_ISSUE
  } sched_state_e;

  typedef struct packed {
    logic [CH_IDX_W-1:0] ch;
    logic                last;
  } ost_ent_t;
endpackage

// File: rtl/dmac_rr_arbiter.sv
// Round-robin channel arbiter: first requester at or after
// rr_ptr wins, wrapping past the last channel.
module dmac_rr_arbiter #(
  parameter int CHANNEL_COUNT = 8
) (
  input  logic [CHANNEL_COUNT-1:0]         req,
  input  logic [$clog2(CHANNEL_COUNT)-1:0] rr_ptr,
  output logic                             gnt_valid,
  output logic [$clog2(CHANNEL_COUNT)-1:0] gnt_idx
);
  localparam int CW = $clog2(CHANNEL_COUNT);

  // rotating priority scan starting at rr_ptr
  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= CHANNEL_COUNT) j = j - CHANNEL_COUNT;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(j);
      end
    end
  end
endmodule

// File: rtl/dmac_write_scheduler.sv
// Per-channel DMA write scheduler with B-response tracking.
// Optional: DMAC_WR_SCHED_BRESP_ERR_EN enables sticky ch_err.
module dmac_write_scheduler
  import dmac_pkg::*;
#(
  parameter int ADDR_WD         = 32,
  parameter int CHANNEL_COUNT   = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [CHANNEL_COUNT-1:0]                     ch_start_valid,
  output logic [CHANNEL_COUNT-1:0]                     ch_start_ready,
  input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]        ch_addr,
  input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]        ch_length,
  input  logic [CHANNEL_COUNT-1:0][BURST_BITS-1:0]     ch_burst,
  input  logic [CHANNEL_COUNT-1:0][SIZE_BITS-1:0]      ch_size,
  input  logic [CHANNEL_COUNT-1:0][$clog2(ADDR_WD/8)-1:0] ch_data_offset,
  input  logic [CHANNEL_COUNT-1:0]                     ch_data_ready,
  output logic [CHANNEL_COUNT-1:0]                     ch_busy,
  output logic [CHANNEL_COUNT-1:0]                     ch_done,
  output logic [CHANNEL_COUNT-1:0]                     ch_err,
  output logic                                         wr_req_valid,
  input  logic                                         wr_req_ack,
  output logic [ADDR_WD-1:0]                           wr_req_addr,
  output logic [ADDR_WD-1:0]                           wr_req_length,
  output logic [BURST_BITS-1:0]                        wr_req_burst,
  output logic [SIZE_BITS-1:0]                         wr_req_size,
  output logic [$clog2(ADDR_WD/8)-1:0]                 wr_req_data_offset,
  output logic [$clog2(CHANNEL_COUNT)-1:0]             wr_req_ch,
  input  logic [ADDR_WD-1:0]                           wr_req_next_addr,
  input  logic [ADDR_WD-1:0]                           wr_req_next_length,
  input  logic                                         wr_req_done,
  input  logic                                         m_axi_bvalid,
  output logic                                         m_axi_bready,
  input  logic [1:0]                                   m_axi_bresp
);
  localparam int CW = $clog2(CHANNEL_COUNT);
  localparam int OW = $clog2(ADDR_WD/8);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);

  ch_state_e                               st_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]    addr_q;
  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]    len_q;
  logic [CHANNEL_COUNT-1:0][BURST_BITS-1:0] burst_q;
  logic [CHANNEL_COUNT-1:0][SIZE_BITS-1:0]  size_q;
  logic [CHANNEL_COUNT-1:0][OW-1:0]         off_q;
  logic [CHANNEL_COUNT-1:0]                 zdone_q;

  sched_state_e ss_q, ss_d;
  logic [CW-1:0] gnt_q, rr_q;

  ost_ent_t      fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wp_q, rp_q;
  logic [NW-1:0] cnt_q;

  logic                     full, empty, push, bfire;
  ost_ent_t                 head;
  logic [CHANNEL_COUNT-1:0] elig, start_acc, retire, bmatch;
  logic                     arb_valid;
  logic [CW-1:0]            arb_idx;

  assign full  = (cnt_q == NW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign push  = (ss_q == S_ISSUE) && wr_req_ack;
  assign bfire = m_axi_bvalid && !empty;
  assign head  = fifo_q[rp_q];

  // per-channel eligibility, start handshake and retire decode
  always_comb begin
    elig      = '0;
    start_acc = '0;
    retire    = '0;
    bmatch    = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      elig[i]      = (st_q[i] == CH_ACTIVE) && ch_data_ready[i] && !full;
      start_acc[i] = ch_start_valid[i] && (st_q[i] == CH_IDLE);
      bmatch[i]    = bfire && (head.ch == CH_IDX_W'(i));
      retire[i]    = bmatch[i] && head.last;
    end
  end

  dmac_rr_arbiter #(
    .CHANNEL_COUNT(CHANNEL_COUNT)
  ) u_arb (
    .req      (elig),
    .rr_ptr   (rr_q),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  // scheduler next state
  always_comb begin
    ss_d = ss_q;
    unique case (ss_q)
      S_ARB:   if (arb_valid) ss_d = S_ISSUE;
      S_ISSUE: if (wr_req_ack) ss_d = S_ARB;
    endcase
  end

  // scheduler state, grant latch and fairness pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q  <= S_ARB;
      gnt_q <= '0;
      rr_q  <= '0;
    end else begin
      ss_q <= ss_d;
      if (ss_q == S_ARB && arb_valid) gnt_q <= arb_idx;
      if (push)
        rr_q <= (gnt_q == CW'(CHANNEL_COUNT-1)) ? '0 : gnt_q + 1'b1;
    end
  end

  // outstanding-burst FIFO, popped in order by B responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_OUTSTANDING; k++) fifo_q[k] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= '{ch: CH_IDX_W'(gnt_q), last: wr_req_done};
        wp_q <= (wp_q == PW'(MAX_OUTSTANDING-1)) ? '0 : wp_q + 1'b1;
      end
      if (bfire)
        rp_q <= (rp_q == PW'(MAX_OUTSTANDING-1)) ? '0 : rp_q + 1'b1;
      if (push && !bfire) cnt_q <= cnt_q + 1'b1;
      else if (!push && bfire) cnt_q <= cnt_q - 1'b1;
    end
  end

  // channel descriptor registers and lifecycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) st_q[i] <= CH_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      zdone_q <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        zdone_q[i] <= 1'b0;
        if (start_acc[i]) begin
          addr_q[i]  <= ch_addr[i];
          len_q[i]   <= ch_length[i];
          burst_q[i] <= ch_burst[i];
          size_q[i]  <= ch_size[i];
          off_q[i]   <= ch_data_offset[i];
          if (ch_length[i] == '0) zdone_q[i] <= 1'b1;
          else st_q[i] <= CH_ACTIVE;
        end
        if (push && gnt_q == CW'(i)) begin
          addr_q[i] <= wr_req_next_addr;
          len_q[i]  <= wr_req_next_length;
          if (wr_req_done) st_q[i] <= CH_DRAIN;
        end
        if (retire[i]) st_q[i] <= CH_IDLE;
      end
    end
  end

`ifdef DMAC_WR_SCHED_BRESP_ERR_EN
  logic [CHANNEL_COUNT-1:0] err_q;

  // sticky error on SLVERR/DECERR, cleared by a new start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (start_acc[i]) err_q[i] <= 1'b0;
        else if (bmatch[i] && m_axi_bresp[1]) err_q[i] <= 1'b1;
      end
    end
  end

  assign ch_err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
  assign ch_err       = '0;
`endif

  // channel status outputs
  always_comb begin
    ch_start_ready = '0;
    ch_busy        = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      ch_start_ready[i] = (st_q[i] == CH_IDLE);
      ch_busy[i]        = (st_q[i] != CH_IDLE);
    end
  end

  assign ch_done            = zdone_q | retire;
  assign m_axi_bready       = !empty;
  assign wr_req_valid       = (ss_q == S_ISSUE);
  assign wr_req_ch          = gnt_q;
  assign wr_req_addr        = addr_q[gnt_q];
  assign wr_req_length      = len_q[gnt_q];
  assign wr_req_burst       = burst_q[gnt_q];
  assign wr_req_size        = size_q[gnt_q];
  assign wr_req_data_offset = off_q[gnt_q];
endmodule
